inv_sub_bytes_iter: RTL and testbench

- Iterative InvSubBytes stage for the AES-128 decryption round, placed directly downstream of the inverse ShiftRows layer.
- Captures one 128-bit state from a valid/ready handshake and applies the inverse S-box to BPC bytes per clock, using BPC shared lookup instances.
- Presents the substituted state on a valid/ready output toward AddRoundKey.
- Trades latency for area compared with a fully parallel 16-S-box layer.

---
 rtl/inv_sub_bytes_iter_pkg.sv | 18 +
 rtl/inv_sub_bytes_iter_inv_sbox.sv | 47 ++++
 rtl/inv_sub_bytes_iter.sv | 113 +++++++++++
 tb/tb_inv_sub_bytes_iter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inv_sub_bytes_iter_pkg.sv
// Shared AES widths, FSM encoding and parameter legality check for the
// iterative InvSubBytes stage.
package inv_sub_bytes_iter_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic bit bpc_legal(input int bpc);
    return (bpc == 1) || (bpc == 2) || (bpc == 4) || (bpc == 8) || (bpc == 16);
  endfunction

endpackage

// File: rtl/inv_sub_bytes_iter_inv_sbox.sv
// Combinational FIPS-197 inverse S-box, one byte in, one byte out.
// Also used by the fully parallel decryption datapath.
module inv_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  always_comb begin
    out_o = 8'h00;
    case (in_i)
      8'h00: out_o = 8'h52; 8'h01: out_o = 8'h09; 8'h02: out_o = 8'h6a; 8'h03: out_o = 8'hd5; 8'h04: out_o = 8'h30; 8'h05: out_o = 8'h36; 8'h06: out_o = 8'ha5; 8'h07: out_o = 8'h38;
      8'h08: out_o = 8'hbf; 8'h09: out_o = 8'h40; 8'h0a: out_o = 8'ha3; 8'h0b: out_o = 8'h9e; 8'h0c: out_o = 8'h81; 8'h0d: out_o = 8'hf3; 8'h0e: out_o = 8'hd7; 8'h0f: out_o = 8'hfb;
      8'h10: out_o = 8'h7c; 8'h11: out_o = 8'he3; 8'h12: out_o = 8'h39; 8'h13: out_o = 8'h82; 8'h14: out_o = 8'h9b; 8'h15: out_o = 8'h2f; 8'h16: out_o = 8'hff; 8'h17: out_o = 8'h87;
      8'h18: out_o = 8'h34; 8'h19: out_o = 8'h8e; 8'h1a: out_o = 8'h43; 8'h1b: out_o = 8'h44; 8'h1c: out_o = 8'hc4; 8'h1d: out_o = 8'hde; 8'h1e: out_o = 8'he9; 8'h1f: out_o = 8'hcb;
      8'h20: out_o = 8'h54; 8'h21: out_o = 8'h7b; 8'h22: out_o = 8'h94; 8'h23: out_o = 8'h32; 8'h24: out_o = 8'ha6; 8'h25: out_o = 8'hc2; 8'h26: out_o = 8'h23; 8'h27: out_o = 8'h3d;
      8'h28: out_o = 8'hee; 8'h29: out_o = 8'h4c; 8'h2a: out_o = 8'h95; 8'h2b: out_o = 8'h0b; 8'h2c: out_o = 8'h42; 8'h2d: out_o = 8'hfa; 8'h2e: out_o = 8'hc3; 8'h2f: out_o = 8'h4e;
      8'h30: out_o = 8'h08; 8'h31: out_o = 8'h2e; 8'h32: out_o = 8'ha1; 8'h33: out_o = 8'h66; 8'h34: out_o = 8'h28; 8'h35: out_o = 8'hd9; 8'h36: out_o = 8'h24; 8'h37: out_o = 8'hb2;
      8'h38: out_o = 8'h76; 8'h39: out_o = 8'h5b; 8'h3a: out_o = 8'ha2; 8'h3b: out_o = 8'h49; 8'h3c: out_o = 8'h6d; 8'h3d: out_o = 8'h8b; 8'h3e: out_o = 8'hd1; 8'h3f: out_o = 8'h25;
      8'h40: out_o = 8'h72; 8'h41: out_o = 8'hf8; 8'h42: out_o = 8'hf6; 8'h43: out_o = 8'h64; 8'h44: out_o = 8'h86; 8'h45: out_o = 8'h68; 8'h46: out_o = 8'h98; 8'h47: out_o = 8'h16;
      8'h48: out_o = 8'hd4; 8'h49: out_o = 8'ha4; 8'h4a: out_o = 8'h5c; 8'h4b: out_o = 8'hcc; 8'h4c: out_o = 8'h5d; 8'h4d: out_o = 8'h65; 8'h4e: out_o = 8'hb6; 8'h4f: out_o = 8'h92;
      8'h50: out_o = 8'h6c; 8'h51: out_o = 8'h70; 8'h52: out_o = 8'h48; 8'h53: out_o = 8'h50; 8'h54: out_o = 8'hfd; 8'h55: out_o = 8'hed; 8'h56: out_o = 8'hb9; 8'h57: out_o = 8'hda;
      8'h58: out_o = 8'h5e; 8'h59: out_o = 8'h15; 8'h5a: out_o = 8'h46; 8'h5b: out_o = 8'h57; 8'h5c: out_o = 8'ha7; 8'h5d: out_o = 8'h8d; 8'h5e: out_o = 8'h9d; 8'h5f: out_o = 8'h84;
      8'h60: out_o = 8'h90; 8'h61: out_o = 8'hd8; 8'h62: out_o = 8'hab; 8'h63: out_o = 8'h00; 8'h64: out_o = 8'h8c; 8'h65: out_o = 8'hbc; 8'h66: out_o = 8'hd3; 8'h67: out_o = 8'h0a;
      8'h68: out_o = 8'hf7; 8'h69: out_o = 8'he4; 8'h6a: out_o = 8'h58; 8'h6b: out_o = 8'h05; 8'h6c: out_o = 8'hb8; 8'h6d: out_o = 8'hb3; 8'h6e: out_o = 8'h45; 8'h6f: out_o = 8'h06;
      8'h70: out_o = 8'hd0; 8'h71: out_o = 8'h2c; 8'h72: out_o = 8'h1e; 8'h73: out_o = 8'h8f; 8'h74: out_o = 8'hca; 8'h75: out_o = 8'h3f; 8'h76: out_o = 8'h0f; 8'h77: out_o = 8'h02;
      8'h78: out_o = 8'hc1; 8'h79: out_o = 8'haf; 8'h7a: out_o = 8'hbd; 8'h7b: out_o = 8'h03; 8'h7c: out_o = 8'h01; 8'h7d: out_o = 8'h13; 8'h7e: out_o = 8'h8a; 8'h7f: out_o = 8'h6b;
      8'h80: out_o = 8'h3a; 8'h81: out_o = 8'h91; 8'h82: out_o = 8'h11; 8'h83: out_o = 8'h41; 8'h84: out_o = 8'h4f; 8'h85: out_o = 8'h67; 8'h86: out_o = 8'hdc; 8'h87: out_o = 8'hea;
      8'h88: out_o = 8'h97; 8'h89: out_o = 8'hf2; 8'h8a: out_o = 8'hcf; 8'h8b: out_o = 8'hce; 8'h8c: out_o = 8'hf0; 8'h8d: out_o = 8'hb4; 8'h8e: out_o = 8'he6; 8'h8f: out_o = 8'h73;
      8'h90: out_o = 8'h96; 8'h91: out_o = 8'hac; 8'h92: out_o = 8'h74; 8'h93: out_o = 8'h22; 8'h94: out_o = 8'he7; 8'h95: out_o = 8'had; 8'h96: out_o = 8'h35; 8'h97: out_o = 8'h85;
      8'h98: out_o = 8'he2; 8'h99: out_o = 8'hf9; 8'h9a: out_o = 8'h37; 8'h9b: out_o = 8'he8; 8'h9c: out_o = 8'h1c; 8'h9d: out_o = 8'h75; 8'h9e: out_o = 8'hdf; 8'h9f: out_o = 8'h6e;
      8'ha0: out_o = 8'h47; 8'ha1: out_o = 8'hf1; 8'ha2: out_o = 8'h1a; 8'ha3: out_o = 8'h71; 8'ha4: out_o = 8'h1d; 8'ha5: out_o = 8'h29; 8'ha6: out_o = 8'hc5; 8'ha7: out_o = 8'h89;
      8'ha8: out_o = 8'h6f; 8'ha9: out_o = 8'hb7; 8'haa: out_o = 8'h62; 8'hab: out_o = 8'h0e; 8'hac: out_o = 8'haa; 8'had: out_o = 8'h18; 8'hae: out_o = 8'hbe; 8'haf: out_o = 8'h1b;
      8'hb0: out_o = 8'hfc; 8'hb1: out_o = 8'h56; 8'hb2: out_o = 8'h3e; 8'hb3: out_o = 8'h4b; 8'hb4: out_o = 8'hc6; 8'hb5: out_o = 8'hd2; 8'hb6: out_o = 8'h79; 8'hb7: out_o = 8'h20;
      8'hb8: out_o = 8'h9a; 8'hb9: out_o = 8'hdb; 8'hba: out_o = 8'hc0; 8'hbb: out_o = 8'hfe; 8'hbc: out_o = 8'h78; 8'hbd: out_o = 8'hcd; 8'hbe: out_o = 8'h5a; 8'hbf: out_o = 8'hf4;
      8'hc0: out_o = 8'h1f; 8'hc1: out_o = 8'hdd; 8'hc2: out_o = 8'ha8; 8'hc3: out_o = 8'h33; 8'hc4: out_o = 8'h88; 8'hc5: out_o = 8'h07; 8'hc6: out_o = 8'hc7; 8'hc7: out_o = 8'h31;
      8'hc8: out_o = 8'hb1; 8'hc9: out_o = 8'h12; 8'hca: out_o = 8'h10; 8'hcb: out_o = 8'h59; 8'hcc: out_o = 8'h27; 8'hcd: out_o = 8'h80; 8'hce: out_o = 8'hec; 8'hcf: out_o = 8'h5f;
      8'hd0: out_o = 8'h60; 8'hd1: out_o = 8'h51; 8'hd2: out_o = 8'h7f; 8'hd3: out_o = 8'ha9; 8'hd4: out_o = 8'h19; 8'hd5: out_o = 8'hb5; 8'hd6: out_o = 8'h4a; 8'hd7: out_o = 8'h0d;
      8'hd8: out_o = 8'h2d; 8'hd9: out_o = 8'he5; 8'hda: out_o = 8'h7a; 8'hdb: out_o = 8'h9f; 8'hdc: out_o = 8'h93; 8'hdd: out_o = 8'hc9; 8'hde: out_o = 8'h9c; 8'hdf: out_o = 8'hef;
      8'he0: out_o = 8'ha0; 8'he1: out_o = 8'he0; 8'he2: out_o = 8'h3b; 8'he3: out_o = 8'h4d; 8'he4: out_o = 8'hae; 8'he5: out_o = 8'h2a; 8'he6: out_o = 8'hf5; 8'he7: out_o = 8'hb0;
      8'he8: out_o = 8'hc8; 8'he9: out_o = 8'heb; 8'hea: out_o = 8'hbb; 8'heb: out_o = 8'h3c; 8'hec: out_o = 8'h83; 8'hed: out_o = 8'h53; 8'hee: out_o = 8'h99; 8'hef: out_o = 8'h61;
      8'hf0: out_o = 8'h17; 8'hf1: out_o = 8'h2b; 8'hf2: out_o = 8'h04; 8'hf3: out_o = 8'h7e; 8'hf4: out_o = 8'hba; 8'hf5: out_o = 8'h77; 8'hf6: out_o = 8'hd6; 8'hf7: out_o = 8'h26;
      8'hf8: out_o = 8'he1; 8'hf9: out_o = 8'h69; 8'hfa: out_o = 8'h14; 8'hfb: out_o = 8'h63; 8'hfc: out_o = 8'h55; 8'hfd: out_o = 8'h21; 8'hfe: out_o = 8'h0c; 8'hff: out_o = 8'h7d;
      default: out_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: captures one AES state, substitutes BPC bytes per
// clock through shared inverse S-boxes, then holds the result for AddRoundKey.
module inv_sub_bytes_iter
  import inv_sub_bytes_iter_pkg::*;
#(
  parameter int BPC = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   busy
);

  localparam int NCYC  = 16 / BPC;
  localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam int CW    = BPC * AES_BYTE_W;
  localparam int NSEL  = 1 << CNT_W;

  if (!bpc_legal(BPC)) begin : g_bpc_check
    $fatal(1, "inv_sub_bytes_iter: BPC must be 1, 2, 4, 8 or 16");
  end

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [AES_STATE_W-1:0] work_q, work_d, work_sub;
  logic [CW-1:0]          chunk_sel [NSEL];
  logic [CW-1:0]          chunk_in, chunk_out;
  logic                   ready_raw;

  // Select array is padded to a power of two so cnt_q always indexes in range.
  for (genvar c = 0; c < NSEL; c++) begin : g_sel
    if (c < NCYC) begin : g_used
      assign chunk_sel[c] = work_q[c*CW +: CW];
    end else begin : g_pad
      assign chunk_sel[c] = '0;
    end
  end
  assign chunk_in = chunk_sel[cnt_q];

  for (genvar b = 0; b < BPC; b++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .in_i  (chunk_in[b*AES_BYTE_W +: AES_BYTE_W]),
      .out_o (chunk_out[b*AES_BYTE_W +: AES_BYTE_W])
    );
  end

  for (genvar c = 0; c < NCYC; c++) begin : g_wr
    assign work_sub[c*CW +: CW] = (cnt_q == CNT_W'(c)) ? chunk_out : work_q[c*CW +: CW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  // IDLE: accept a state | BUSY: substitute one chunk per cycle | DONE: hold result
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    ready_raw = 1'b0;
    case (state_q)
      IDLE: begin
        ready_raw = 1'b1;
        if (in_valid) begin
          work_d  = in_state;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        work_d = work_sub;
        if (cnt_q == CNT_W'(NCYC - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        ready_raw = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            work_d  = in_state;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = ready_raw & rst_n;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign out_state = (state_q == DONE) ? work_q : '0;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter: five BPC variants share stimulus and are checked
// against an inverse S-box derived from GF(2^8) arithmetic.
module tb_inv_sub_bytes_iter;

  localparam int NDUT = 5;

  function automatic int bpc_of(input int g);
    case (g)
      0: return 4;
      1: return 1;
      2: return 2;
      3: return 8;
      default: return 16;
    endcase
  endfunction

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] in_state = '0;
  logic         in_ready  [NDUT];
  logic         out_valid [NDUT];
  logic         busy      [NDUT];
  logic [127:0] out_state [NDUT];

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]   inv_tab [256];
  int           lat      [NDUT];
  int           bcnt     [NDUT];
  bit           unstable [NDUT];
  bit           rdy_leak [NDUT];
  logic         acc_rdy  [NDUT];
  logic [127:0] res      [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    inv_sub_bytes_iter #(.BPC(bpc_of(g))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .in_state  (in_state),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .out_state (out_state[g]),
      .busy      (busy[g])
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] w;
    w = {v, v} << n;
    return w[15:8];
  endfunction

  // Forward S-box from multiplicative inverse + affine map, then inverted.
  task automatic build_tables();
    logic [7:0] b, s;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_inv(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Presents one block (out_ready high on the accept cycle), then holds
  // out_ready low for 20 cycles while recording latency, busy count and stability.
  task automatic run_block(input logic [127:0] st, input bit scramble, input bit drain);
    logic [127:0] first_out [NDUT];
    @(negedge clk);
    in_valid = 1'b1; in_state = st; out_ready = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      acc_rdy[k] = in_ready[k]; lat[k] = -1; bcnt[k] = 0;
      unstable[k] = 1'b0; rdy_leak[k] = 1'b0; first_out[k] = '0;
    end
    @(negedge clk);
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid = scramble ? 1'($urandom_range(0, 1)) : 1'b0;
      if (scramble) in_state = rand_state();
      #1;
      for (int k = 0; k < NDUT; k++) begin
        if (busy[k]) bcnt[k]++;
        if (out_valid[k]) begin
          if (lat[k] < 0) begin
            lat[k] = cyc; first_out[k] = out_state[k];
          end else if (out_state[k] !== first_out[k]) begin
            unstable[k] = 1'b1;
          end
          if (in_ready[k] !== 1'b0) rdy_leak[k] = 1'b1;
        end
      end
      @(negedge clk);
    end
    for (int k = 0; k < NDUT; k++) res[k] = out_state[k];
    in_valid = 1'b0;
    if (drain) begin
      out_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_state = rand_state(); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      n_cmp++; if (in_ready[k] !== 1'b0) begin n_err++; $display("FAIL reset_in_ready bpc=%0d: got %b want 0", bpc_of(k), in_ready[k]); end
      n_cmp++; if (out_valid[k] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid bpc=%0d: got %b want 0", bpc_of(k), out_valid[k]); end
      n_cmp++; if (busy[k] !== 1'b0) begin n_err++; $display("FAIL reset_busy bpc=%0d: got %b want 0", bpc_of(k), busy[k]); end
      n_cmp++; if (out_state[k] !== 128'h0) begin n_err++; $display("FAIL reset_out_state bpc=%0d: got %h want 0", bpc_of(k), out_state[k]); end
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      n_cmp++; if (in_ready[k] !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready bpc=%0d: got %b want 1", bpc_of(k), in_ready[k]); end
      n_cmp++; if (out_valid[k] !== 1'b0) begin n_err++; $display("FAIL post_reset_out_valid bpc=%0d: got %b want 0", bpc_of(k), out_valid[k]); end
    end
  endtask

  task automatic test_known_vectors();
    logic [7:0]   pin [4];
    logic [7:0]   pout [4];
    logic [127:0] st, exp;
    pin  = '{8'h7c, 8'h16, 8'h52, 8'h63};
    pout = '{8'h01, 8'hff, 8'h48, 8'h00};
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 16; i++) begin
        case (v)
          0: begin st[8*i +: 8] = 8'h63; exp[8*i +: 8] = 8'h00; end
          1: begin st[8*i +: 8] = 8'h00; exp[8*i +: 8] = 8'h52; end
          default: begin st[8*i +: 8] = pin[i % 4]; exp[8*i +: 8] = pout[i % 4]; end
        endcase
      end
      run_block(st, 1'b0, 1'b1);
      for (int k = 0; k < NDUT; k++) begin
        n_cmp++; if (res[k] !== exp) begin n_err++; $display("FAIL known_vec%0d bpc=%0d: got %h want %h", v, bpc_of(k), res[k], exp); end
        n_cmp++; if (lat[k] != 16 / bpc_of(k)) begin n_err++; $display("FAIL known_latency bpc=%0d: got %0d want %0d", bpc_of(k), lat[k], 16 / bpc_of(k)); end
        n_cmp++; if (bcnt[k] != 16 / bpc_of(k)) begin n_err++; $display("FAIL known_busy_cycles bpc=%0d: got %0d want %0d", bpc_of(k), bcnt[k], 16 / bpc_of(k)); end
        n_cmp++; if (out_valid[k] !== 1'b0) begin n_err++; $display("FAIL drained_out_valid bpc=%0d: got %b want 0", bpc_of(k), out_valid[k]); end
      end
    end
  endtask

  task automatic test_random_sweep();
    logic [127:0] st, exp;
    for (int it = 0; it < 6; it++) begin
      st = rand_state(); exp = ref_inv(st);
      run_block(st, 1'b0, 1'b1);
      for (int k = 0; k < NDUT; k++) begin
        n_cmp++; if (res[k] !== exp) begin n_err++; $display("FAIL sweep_result bpc=%0d: got %h want %h", bpc_of(k), res[k], exp); end
        n_cmp++; if (lat[k] != 16 / bpc_of(k)) begin n_err++; $display("FAIL sweep_latency bpc=%0d: got %0d want %0d", bpc_of(k), lat[k], 16 / bpc_of(k)); end
      end
    end
  endtask

  task automatic test_input_change();
    logic [127:0] st, exp;
    st = rand_state(); exp = ref_inv(st);
    run_block(st, 1'b1, 1'b1);
    for (int k = 0; k < NDUT; k++) begin
      n_cmp++; if (res[k] !== exp) begin n_err++; $display("FAIL capture_once bpc=%0d: got %h want %h", bpc_of(k), res[k], exp); end
      n_cmp++; if (lat[k] != 16 / bpc_of(k)) begin n_err++; $display("FAIL capture_latency bpc=%0d: got %0d want %0d", bpc_of(k), lat[k], 16 / bpc_of(k)); end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] sa, sb;
    sa = rand_state(); sb = rand_state();
    run_block(sa, 1'b1, 1'b0);
    for (int k = 0; k < NDUT; k++) begin
      n_cmp++; if (res[k] !== ref_inv(sa)) begin n_err++; $display("FAIL bp_hold_result bpc=%0d: got %h want %h", bpc_of(k), res[k], ref_inv(sa)); end
      n_cmp++; if (unstable[k] !== 1'b0) begin n_err++; $display("FAIL bp_stable bpc=%0d: got changed=%b want 0", bpc_of(k), unstable[k]); end
      n_cmp++; if (rdy_leak[k] !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_low bpc=%0d: got leak=%b want 0", bpc_of(k), rdy_leak[k]); end
    end
    run_block(sb, 1'b1, 1'b1);
    for (int k = 0; k < NDUT; k++) begin
      n_cmp++; if (acc_rdy[k] !== 1'b1) begin n_err++; $display("FAIL handoff_in_ready bpc=%0d: got %b want 1", bpc_of(k), acc_rdy[k]); end
      n_cmp++; if (res[k] !== ref_inv(sb)) begin n_err++; $display("FAIL handoff_result bpc=%0d: got %h want %h", bpc_of(k), res[k], ref_inv(sb)); end
      n_cmp++; if (lat[k] != 16 / bpc_of(k)) begin n_err++; $display("FAIL handoff_latency bpc=%0d: got %0d want %0d", bpc_of(k), lat[k], 16 / bpc_of(k)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] st, exp;
    int last_hi [NDUT];
    int rises   [NDUT];
    st = rand_state(); exp = ref_inv(st);
    for (int k = 0; k < NDUT; k++) begin last_hi[k] = -1; rises[k] = 0; end
    @(negedge clk);
    in_valid = 1'b1; in_state = st; out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        if (out_valid[k]) begin
          rises[k]++;
          n_cmp++; if (out_state[k] !== exp) begin n_err++; $display("FAIL b2b_result bpc=%0d: got %h want %h", bpc_of(k), out_state[k], exp); end
          if (last_hi[k] >= 0) begin
            n_cmp++; if (cyc - last_hi[k] != 16 / bpc_of(k) + 1) begin n_err++; $display("FAIL b2b_spacing bpc=%0d: got %0d want %0d", bpc_of(k), cyc - last_hi[k], 16 / bpc_of(k) + 1); end
          end
          last_hi[k] = cyc;
        end
      end
    end
    for (int k = 0; k < NDUT; k++) begin
      n_cmp++; if (rises[k] < 2) begin n_err++; $display("FAIL b2b_count bpc=%0d: got %0d want >=2", bpc_of(k), rises[k]); end
    end
    in_valid = 1'b0;
    repeat (18) @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    bit spurious [NDUT];
    @(negedge clk);
    in_valid = 1'b1; in_state = rand_state(); out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      spurious[k] = 1'b0;
      n_cmp++; if (out_state[k] !== 128'h0) begin n_err++; $display("FAIL midrst_out_state bpc=%0d: got %h want 0", bpc_of(k), out_state[k]); end
      n_cmp++; if (out_valid[k] !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid bpc=%0d: got %b want 0", bpc_of(k), out_valid[k]); end
      n_cmp++; if (busy[k] !== 1'b0) begin n_err++; $display("FAIL midrst_busy bpc=%0d: got %b want 0", bpc_of(k), busy[k]); end
      n_cmp++; if (in_ready[k] !== 1'b0) begin n_err++; $display("FAIL midrst_in_ready bpc=%0d: got %b want 0", bpc_of(k), in_ready[k]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      n_cmp++; if (in_ready[k] !== 1'b1) begin n_err++; $display("FAIL midrst_idle_ready bpc=%0d: got %b want 1", bpc_of(k), in_ready[k]); end
      n_cmp++; if (busy[k] !== 1'b0) begin n_err++; $display("FAIL midrst_idle_busy bpc=%0d: got %b want 0", bpc_of(k), busy[k]); end
    end
    repeat (20) begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) if (out_valid[k] !== 1'b0) spurious[k] = 1'b1;
    end
    for (int k = 0; k < NDUT; k++) begin
      n_cmp++; if (spurious[k] !== 1'b0) begin n_err++; $display("FAIL midrst_spurious_valid bpc=%0d: got %b want 0", bpc_of(k), spurious[k]); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_tables();
    test_reset();
    test_known_vectors();
    test_random_sweep();
    test_input_change();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
